// File: rtl/decode_queue_stage.sv
// ---------------------------------------------------------------------------
// decode_queue_stage
//
// RISC-V instruction decode stage with a DEPTH-entry queue of decoded
// instructions sitting between fetch and execute.  Every instruction
// accepted from fetch is decoded combinationally.  The decoded record is
// written into the queue, so a push at edge N shows up at the outputs right
// after edge N when the queue was empty.  The head entry is offered
// downstream over a valid/ready handshake.
//
// Parameters
//   DEPTH : queue entries (power of two, >= 2)
//   XLEN  : immediate width (32 or 64)
//   PC_W  : program-counter width
//   RV64  : 1 = OP-32 / OP-IMM-32 opcodes legal, 0 = illegal
//   CNT_W : width of the saturating illegal-instruction counter
//
// Ports
//   clk, rstn          : clock, synchronous active-low reset
//   flush              : drop every queued entry (wins over push and pop)
//   in_valid/in_ready  : fetch handshake; in_ready = (count != DEPTH)
//   in_inst, in_pc     : raw instruction and its PC
//   out_valid/out_ready: execute handshake; out_valid = (count != 0)
//   out_*              : decoded fields of the head entry (all 0 when empty)
//   illegal_cnt        : saturating number of illegal instructions pushed
//   count              : queue occupancy
// ---------------------------------------------------------------------------
module decode_queue_stage #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64,
    parameter int PC_W  = 64,
    parameter int RV64  = 1,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_inst,
    input  logic [PC_W-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [31:0]              out_inst,
    output logic [3:0]               out_class,
    output logic [4:0]               out_rd,
    output logic [4:0]               out_rs1,
    output logic [4:0]               out_rs2,
    output logic [2:0]               out_funct3,
    output logic [XLEN-1:0]          out_imm,
    output logic                     out_we_reg,
    output logic                     out_use_rs1,
    output logic                     out_use_rs2,
    output logic                     out_word,
    output logic                     out_illegal,
    output logic                     out_ecall,
    output logic                     out_ebreak,
    output logic                     out_mret,
    output logic [CNT_W-1:0]         illegal_cnt,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [3:0] CLS_R     = 4'd0;
    localparam logic [3:0] CLS_I     = 4'd1;
    localparam logic [3:0] CLS_LOAD  = 4'd2;
    localparam logic [3:0] CLS_STORE = 4'd3;
    localparam logic [3:0] CLS_BR    = 4'd4;
    localparam logic [3:0] CLS_LUI   = 4'd5;
    localparam logic [3:0] CLS_AUIPC = 4'd6;
    localparam logic [3:0] CLS_JAL   = 4'd7;
    localparam logic [3:0] CLS_JALR  = 4'd8;
    localparam logic [3:0] CLS_SYS   = 4'd9;
    localparam logic [3:0] CLS_ILL   = 4'd15;

    // One decoded queue entry.
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     inst;
        logic [3:0]      cls;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [XLEN-1:0] imm;
        logic            we_reg;
        logic            use_rs1;
        logic            use_rs2;
        logic            word;
        logic            illegal;
        logic            ecall;
        logic            ebreak;
        logic            mret;
    } entry_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

    logic push;
    logic pop;

    // ------------------------------------------------------------------
    // Decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [4:0]      opcode;
    logic [2:0]      funct3;
    logic            is_ecall;
    logic            is_ebreak;
    logic            is_mret;
    logic [3:0]      dec_cls;
    logic            dec_word;
    logic            rd_used;
    logic            rs1_used;
    logic            rs2_used;
    logic [31:0]     imm32;
    logic [XLEN-1:0] dec_imm;
    entry_t          dec_entry;

    always_comb begin
        opcode    = in_inst[6:2];
        funct3    = in_inst[14:12];
        is_ecall  = (in_inst == 32'h0000_0073);
        is_ebreak = (in_inst == 32'h0010_0073);
        is_mret   = (in_inst == 32'h3020_0073);
        dec_cls   = CLS_ILL;
        dec_word  = 1'b0;
        // Compressed encodings (low bits != 11) are never legal here.
        if (in_inst[1:0] == 2'b11) begin
            case (opcode)
                5'b01100: dec_cls = CLS_R;
                5'b00100: dec_cls = CLS_I;
                5'b00000: dec_cls = CLS_LOAD;
                5'b01000: dec_cls = CLS_STORE;
                5'b11000: dec_cls = CLS_BR;
                5'b01101: dec_cls = CLS_LUI;
                5'b00101: dec_cls = CLS_AUIPC;
                5'b11011: dec_cls = CLS_JAL;
                5'b11001: dec_cls = CLS_JALR;
                5'b11100: dec_cls = CLS_SYS;
                5'b01110: begin
                    if (RV64 != 0) begin
                        dec_cls  = CLS_R;
                        dec_word = 1'b1;
                    end
                end
                5'b00110: begin
                    if (RV64 != 0) begin
                        dec_cls  = CLS_I;
                        dec_word = 1'b1;
                    end
                end
                default: dec_cls = CLS_ILL;
            endcase
        end
        // funct3=000 in SYSTEM space is only legal for the three exact
        // privileged encodings; CSR forms (funct3 != 0) pass unchecked.
        if (dec_cls == CLS_SYS && funct3 == 3'b000 && !(is_ecall || is_ebreak || is_mret)) begin
            dec_cls = CLS_ILL;
        end
    end

    always_comb begin
        rd_used  = 1'b0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        imm32    = 32'd0;
        case (dec_cls)
            CLS_R: begin
                rd_used  = 1'b1;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            CLS_I, CLS_LOAD, CLS_JALR: begin
                rd_used  = 1'b1;
                rs1_used = 1'b1;
                imm32    = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            CLS_STORE: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                imm32    = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            CLS_BR: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                imm32    = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                            in_inst[30:25], in_inst[11:8], 1'b0};
            end
            CLS_LUI, CLS_AUIPC: begin
                rd_used = 1'b1;
                imm32   = {in_inst[31:12], 12'd0};
            end
            CLS_JAL: begin
                rd_used = 1'b1;
                imm32   = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                           in_inst[20], in_inst[30:21], 1'b0};
            end
            CLS_SYS: begin
                // CSR ops write rd; only the register-source CSR forms
                // (funct3 001..011) read rs1, the others carry a uimm there.
                rd_used  = (funct3 != 3'b000);
                rs1_used = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b011);
                imm32    = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            default: begin
                rd_used  = 1'b0;
                rs1_used = 1'b0;
                rs2_used = 1'b0;
                imm32    = 32'd0;
            end
        endcase
        // Sign-extend to XLEN; works for XLEN == 32 as well.
        dec_imm       = {XLEN{imm32[31]}};
        dec_imm[31:0] = imm32;
    end

    always_comb begin
        dec_entry      = '0;
        dec_entry.pc   = in_pc;
        dec_entry.inst = in_inst;
        dec_entry.cls  = dec_cls;
        if (dec_cls == CLS_ILL) begin
            dec_entry.illegal = 1'b1;
        end else begin
            dec_entry.rd      = rd_used  ? in_inst[11:7]  : 5'd0;
            dec_entry.rs1     = rs1_used ? in_inst[19:15] : 5'd0;
            dec_entry.rs2     = rs2_used ? in_inst[24:20] : 5'd0;
            dec_entry.funct3  = funct3;
            dec_entry.imm     = dec_imm;
            dec_entry.we_reg  = rd_used && (in_inst[11:7] != 5'd0);
            dec_entry.use_rs1 = rs1_used;
            dec_entry.use_rs2 = rs2_used;
            dec_entry.word    = dec_word;
            dec_entry.ecall   = is_ecall;
            dec_entry.ebreak  = is_ebreak;
            dec_entry.mret    = is_mret;
        end
    end

    // ------------------------------------------------------------------
    // Queue control
    // ------------------------------------------------------------------
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != CW'(0));
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push) begin
            mem_d[wr_ptr_q] = dec_entry;
        end
    end

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        illegal_cnt_d = illegal_cnt_q;
        // Power-of-two depth: pointer wrap is plain overflow.
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        if (push && dec_entry.illegal && (illegal_cnt_q != {CNT_W{1'b1}})) begin
            illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            illegal_cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Head presentation: fields read 0 whenever the queue is empty, so a
    // flushed queue never exposes stale data.
    // ------------------------------------------------------------------
    entry_t head;

    always_comb begin
        head = '0;
        if (out_valid) begin
            head = mem_q[rd_ptr_q];
        end
    end

    assign out_pc      = head.pc;
    assign out_inst    = head.inst;
    assign out_class   = head.cls;
    assign out_rd      = head.rd;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_funct3  = head.funct3;
    assign out_imm     = head.imm;
    assign out_we_reg  = head.we_reg;
    assign out_use_rs1 = head.use_rs1;
    assign out_use_rs2 = head.use_rs2;
    assign out_word    = head.word;
    assign out_illegal = head.illegal;
    assign out_ecall   = head.ecall;
    assign out_ebreak  = head.ebreak;
    assign out_mret    = head.mret;
    assign illegal_cnt = illegal_cnt_q;
    assign count       = count_q;

endmodule

// File: tb/tb_decode_queue_stage.sv
`timescale 1ns/1ps
module tb_decode_queue_stage;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;

    // DUT A: RV64=1, 16-bit counter
    logic        a_in_ready, a_out_valid;
    logic [63:0] a_out_pc;
    logic [31:0] a_out_inst;
    logic [3:0]  a_class;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [2:0]  a_f3;
    logic [63:0] a_imm;
    logic        a_we, a_u1, a_u2, a_word, a_ill, a_ecall, a_ebreak, a_mret;
    logic [15:0] a_cnt;
    logic [2:0]  a_count;

    // DUT B: RV64=0, 2-bit counter
    logic        b_in_ready, b_out_valid;
    logic [63:0] b_out_pc;
    logic [31:0] b_out_inst;
    logic [3:0]  b_class;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [2:0]  b_f3;
    logic [63:0] b_imm;
    logic        b_we, b_u1, b_u2, b_word, b_ill, b_ecall, b_ebreak, b_mret;
    logic [1:0]  b_cnt;
    logic [2:0]  b_count;

    decode_queue_stage #(.DEPTH(4), .XLEN(64), .PC_W(64), .RV64(1), .CNT_W(16)) dut_a (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_out_pc), .out_inst(a_out_inst), .out_class(a_class), .out_rd(a_rd),
        .out_rs1(a_rs1), .out_rs2(a_rs2), .out_funct3(a_f3), .out_imm(a_imm),
        .out_we_reg(a_we), .out_use_rs1(a_u1), .out_use_rs2(a_u2), .out_word(a_word),
        .out_illegal(a_ill), .out_ecall(a_ecall), .out_ebreak(a_ebreak), .out_mret(a_mret),
        .illegal_cnt(a_cnt), .count(a_count)
    );

    decode_queue_stage #(.DEPTH(4), .XLEN(64), .PC_W(64), .RV64(0), .CNT_W(2)) dut_b (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pc(b_out_pc), .out_inst(b_out_inst), .out_class(b_class), .out_rd(b_rd),
        .out_rs1(b_rs1), .out_rs2(b_rs2), .out_funct3(b_f3), .out_imm(b_imm),
        .out_we_reg(b_we), .out_use_rs1(b_u1), .out_use_rs2(b_u2), .out_word(b_word),
        .out_illegal(b_ill), .out_ecall(b_ecall), .out_ebreak(b_ebreak), .out_mret(b_mret),
        .illegal_cnt(b_cnt), .count(b_count)
    );

    // Decoded fields; flg = {we, use_rs1, use_rs2, word, illegal, ecall, ebreak, mret}
    typedef struct packed {
        logic [3:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [63:0] imm;
        logic [7:0]  flg;
    } dec_t;

    typedef struct {
        logic [31:0] inst;
        dec_t        exp;
    } vec_t;

    logic [189:0] a_head, b_head;
    assign a_head = {a_out_pc, a_out_inst, a_class, a_rd, a_rs1, a_rs2, a_f3, a_imm,
                     a_we, a_u1, a_u2, a_word, a_ill, a_ecall, a_ebreak, a_mret};
    assign b_head = {b_out_pc, b_out_inst, b_class, b_rd, b_rs1, b_rs2, b_f3, b_imm,
                     b_we, b_u1, b_u2, b_word, b_ill, b_ecall, b_ebreak, b_mret};

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: queue of {inst, pc}, illegal counts
    logic [95:0] mq[$];
    int          ill_a;
    int          ill_b;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural decoder written straight from the instruction-set rules.
    function automatic dec_t ref_decode(input logic [31:0] i, input bit rv64);
        dec_t        d;
        int          c;
        bit          wr, r1, r2;
        longint      imm;
        logic [2:0]  f3;
        d  = '0;
        f3 = i[14:12];
        c  = 15;
        if (i[1:0] == 2'b11) begin
            case (i[6:2])
                5'b01100: c = 0;
                5'b00100: c = 1;
                5'b00000: c = 2;
                5'b01000: c = 3;
                5'b11000: c = 4;
                5'b01101: c = 5;
                5'b00101: c = 6;
                5'b11011: c = 7;
                5'b11001: c = 8;
                5'b11100: c = 9;
                5'b01110: c = rv64 ? 0 : 15;
                5'b00110: c = rv64 ? 1 : 15;
                default:  c = 15;
            endcase
        end
        if (c == 9 && f3 == 3'd0 && !(i == 32'h00000073 || i == 32'h00100073 || i == 32'h30200073))
            c = 15;
        if (c == 15) begin
            d.cls = 4'hF;
            d.flg = 8'b0000_1000;
            return d;
        end
        wr = (c inside {0, 1, 2, 5, 6, 7, 8}) || (c == 9 && f3 != 3'd0);
        r1 = (c inside {0, 1, 2, 3, 4, 8}) || (c == 9 && f3 inside {3'd1, 3'd2, 3'd3});
        r2 = (c inside {0, 3, 4});
        case (c)
            1, 2, 8, 9: imm = $signed(i[31:20]);
            3:          imm = $signed({i[31:25], i[11:7]});
            4:          imm = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
            7:          imm = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
            5, 6:       imm = $signed({i[31:12], 12'h000});
            default:    imm = 0;
        endcase
        d.cls = 4'(c);
        d.rd  = wr ? i[11:7]  : 5'd0;
        d.rs1 = r1 ? i[19:15] : 5'd0;
        d.rs2 = r2 ? i[24:20] : 5'd0;
        d.f3  = f3;
        d.imm = imm;
        d.flg = {wr && (i[11:7] != 5'd0), r1, r2,
                 (i[6:2] == 5'b01110) || (i[6:2] == 5'b00110), 1'b0,
                 i == 32'h00000073, i == 32'h00100073, i == 32'h30200073};
        return d;
    endfunction

    task automatic check_all();
        logic [95:0]  e;
        logic [189:0] ea, eb;
        ea = '0;
        eb = '0;
        if (mq.size() != 0) begin
            e  = mq[0];
            ea = {e[63:0], e[95:64], ref_decode(e[95:64], 1'b1)};
            eb = {e[63:0], e[95:64], ref_decode(e[95:64], 1'b0)};
        end
        chk("a_count",     a_count,     mq.size());
        chk("a_in_ready",  a_in_ready,  mq.size() != DEPTH);
        chk("a_out_valid", a_out_valid, mq.size() != 0);
        chk("a_head",      a_head,      ea);
        chk("a_ill_cnt",   a_cnt,       ill_a);
        chk("b_count",     b_count,     mq.size());
        chk("b_in_ready",  b_in_ready,  mq.size() != DEPTH);
        chk("b_out_valid", b_out_valid, mq.size() != 0);
        chk("b_head",      b_head,      eb);
        chk("b_ill_cnt",   b_cnt,       ill_b);
    endtask

    // One clock of stimulus; model updated from the pre-edge state.
    task automatic step(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                        input logic ordy, input logic fl);
        bit push, pop;
        in_valid  = v;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        push = v && (mq.size() != DEPTH) && !fl;
        pop  = (mq.size() != 0) && ordy && !fl;
        @(posedge clk);
        #1;
        if (fl) begin
            mq.delete();
        end else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back({inst, pc});
        end
        if (push) begin
            if (ref_decode(inst, 1'b1).flg[3] && ill_a < 65535) ill_a++;
            if (ref_decode(inst, 1'b0).flg[3] && ill_b < 3)     ill_b++;
        end
        $display("[TB] v=%0b inst=%08h rdy=%0b flush=%0b push=%0b pop=%0b count=%0d",
                 v, inst, ordy, fl, push, pop, mq.size());
        check_all();
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        mq.delete();
        ill_a = 0;
        ill_b = 0;
        $display("[TB] reset");
        check_all();
    endtask

    function automatic dec_t dv(input logic [3:0] c, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [63:0] imm, input logic [7:0] flg);
        return {c, rd, rs1, rs2, f3, imm, flg};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [4:0]  ops [14];
        logic [31:0] sys [4];
        logic [31:0] r;
        int          sel;
        ops = '{5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000, 5'b01101, 5'b00101,
                5'b11011, 5'b11001, 5'b11100, 5'b01110, 5'b00110, 5'b11111, 5'b00010};
        sys = '{32'h00000073, 32'h00100073, 32'h30200073, 32'h00200073};
        r   = $urandom;
        sel = $urandom_range(0, 9);
        if (sel == 0) return r;
        if (sel == 1) return sys[$urandom_range(0, 3)];
        r[6:0] = {ops[$urandom_range(0, 13)], 2'b11};
        return r;
    endfunction

    vec_t        tbl [19];
    logic [31:0] bp_inst [5];

    initial begin
        tbl[0]  = '{32'hFFF00093, dv(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'b11000000)};
        tbl[1]  = '{32'h002081B3, dv(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 64'h0, 8'b11100000)};
        tbl[2]  = '{32'h0000003B, dv(4'd0, 5'd0, 5'd0, 5'd0, 3'd0, 64'h0, 8'b01110000)};
        tbl[3]  = '{32'h0000A103, dv(4'd2, 5'd2, 5'd1, 5'd0, 3'd2, 64'h0, 8'b11000000)};
        tbl[4]  = '{32'hFE532E23, dv(4'd3, 5'd0, 5'd6, 5'd5, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 8'b01100000)};
        tbl[5]  = '{32'hFE208CE3, dv(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 64'hFFFF_FFFF_FFFF_FFF8, 8'b01100000)};
        tbl[6]  = '{32'h800002B7, dv(4'd5, 5'd5, 5'd0, 5'd0, 3'd0, 64'hFFFF_FFFF_8000_0000, 8'b10000000)};
        tbl[7]  = '{32'h12345397, dv(4'd6, 5'd7, 5'd0, 5'd0, 3'd5, 64'h0000_0000_1234_5000, 8'b10000000)};
        tbl[8]  = '{32'h001000EF, dv(4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 64'h800, 8'b10000000)};
        tbl[9]  = '{32'h00008067, dv(4'd8, 5'd0, 5'd1, 5'd0, 3'd0, 64'h0, 8'b01000000)};
        tbl[10] = '{32'h300312F3, dv(4'd9, 5'd5, 5'd6, 5'd0, 3'd1, 64'h300, 8'b11000000)};
        tbl[11] = '{32'h300352F3, dv(4'd9, 5'd5, 5'd0, 5'd0, 3'd5, 64'h300, 8'b10000000)};
        tbl[12] = '{32'h00000073, dv(4'd9, 5'd0, 5'd0, 5'd0, 3'd0, 64'h0, 8'b00000100)};
        tbl[13] = '{32'h00100073, dv(4'd9, 5'd0, 5'd0, 5'd0, 3'd0, 64'h1, 8'b00000010)};
        tbl[14] = '{32'h30200073, dv(4'd9, 5'd0, 5'd0, 5'd0, 3'd0, 64'h302, 8'b00000001)};
        tbl[15] = '{32'h00200073, dv(4'd15, 5'd0, 5'd0, 5'd0, 3'd0, 64'h0, 8'b00001000)};
        tbl[16] = '{32'h00000000, dv(4'd15, 5'd0, 5'd0, 5'd0, 3'd0, 64'h0, 8'b00001000)};
        tbl[17] = '{32'h0000007F, dv(4'd15, 5'd0, 5'd0, 5'd0, 3'd0, 64'h0, 8'b00001000)};
        tbl[18] = '{32'h0010809B, dv(4'd1, 5'd1, 5'd1, 5'd0, 3'd0, 64'h1, 8'b11010000)};
        bp_inst = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213, 32'h00500293};

        do_reset();

        // addi x1,x0,-1 appears one cycle after the push
        step(1'b1, 32'hFFF00093, 64'h1000, 1'b1, 1'b0);
        chk("tp1_valid", a_out_valid, 1'b1);
        chk("tp1_class", a_class, 4'd1);
        chk("tp1_imm",   a_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Decode table against DUT A
        for (int k = 0; k < 19; k++) begin
            step(1'b1, tbl[k].inst, 64'h2000 + 64'(4 * k), 1'b0, 1'b0);
            chk($sformatf("tbl%0d_dec", k), a_head[93:0], tbl[k].exp);
            chk($sformatf("tbl%0d_pc", k), a_out_pc, 64'h2000 + 64'(4 * k));
            step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        end

        // Backpressure: 5 pushes into a 4-deep queue, then drain in order
        for (int k = 0; k < 5; k++) begin
            step(1'b1, bp_inst[k], 64'h3000 + 64'(4 * k), 1'b0, 1'b0);
            if (k == 3) chk("bp_in_ready_full", a_in_ready, 1'b0);
        end
        chk("bp_count_full", a_count, 3'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp_order%0d", k), a_out_inst, bp_inst[k]);
            step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        end
        chk("bp_count_empty", a_count, 3'd0);

        // addw: illegal on RV32 build, legal word op on RV64 build
        do_reset();
        step(1'b1, 32'h0000003B, 64'h4000, 1'b1, 1'b0);
        chk("addw_b_illegal", b_ill, 1'b1);
        chk("addw_b_class",   b_class, 4'd15);
        chk("addw_b_cnt",     b_cnt, 2'd1);
        chk("addw_a_class",   a_class, 4'd0);
        chk("addw_a_word",    a_word, 1'b1);
        chk("addw_a_cnt",     a_cnt, 16'd0);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // SYSTEM exact-match sequence
        step(1'b1, 32'h00000073, 64'h5000, 1'b0, 1'b0);
        step(1'b1, 32'h00100073, 64'h5004, 1'b0, 1'b0);
        step(1'b1, 32'h30200073, 64'h5008, 1'b0, 1'b0);
        step(1'b1, 32'h00200073, 64'h500C, 1'b0, 1'b0);
        chk("sys_ecall", a_ecall, 1'b1);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk("sys_ebreak", a_ebreak, 1'b1);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk("sys_mret", a_mret, 1'b1);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk("sys_illegal", a_ill, 1'b1);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Flush with in_valid high: nothing survives, counter retained
        step(1'b1, 32'h00100093, 64'h6000, 1'b0, 1'b0);
        step(1'b1, 32'h00000000, 64'h6004, 1'b0, 1'b0);
        step(1'b1, 32'h00300193, 64'h6008, 1'b0, 1'b0);
        step(1'b1, 32'h00400213, 64'h600C, 1'b0, 1'b1);
        chk("fl_count",     a_count, 3'd0);
        chk("fl_out_valid", a_out_valid, 1'b0);
        chk("fl_cnt_kept",  a_cnt, 16'(ill_a));
        step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        chk("fl_absent", a_count, 3'd0);

        // Saturation of the 2-bit counter
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 32'h00000000, 64'h7000 + 64'(4 * k), 1'b1, 1'b0);
            chk($sformatf("sat%0d", k), b_cnt, (k < 3) ? 2'(k + 1) : 2'd3);
        end

        // Randomised traffic against the reference model
        do_reset();
        for (int k = 0; k < 300; k++) begin
            step($urandom_range(0, 3) != 0, rand_inst(), {$urandom, $urandom},
                 $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_queue_stage.md
Name: decode_queue_stage

Overview:
- Registered, parametrised RISC-V instruction decode stage with a DEPTH-entry decoded-instruction queue between fetch and execute.
- Each accepted instruction is classified and its immediate, register indices and control flags are extracted. The decoded entry is queued, and the head entry is presented downstream over a valid/ready handshake.
- Adds behaviour the previous combinational decoder lacks: RV32/RV64 mode select, buffering, backpressure, flush, exact illegal detection and a saturating illegal-instruction counter.

Parameters:
DEPTH, 4, queue entries; power of two, at least 2
XLEN, 64, immediate and datapath width; 32 or 64
PC_W, 64, program-counter width
RV64, 1, 1 = OP-32/OP-IMM-32 (opcode[6:2] 01110/00110) legal; 0 = those opcodes illegal
CNT_W, 16, illegal counter width

Ports:
clk  in  1  clock; all state updates on the rising edge
rstn  in  1  reset, synchronous, active-low
flush  in  1  discard all queued entries
in_valid  in  1  fetch presents an instruction
in_ready  out  1  queue can accept; equals (count != DEPTH)
in_inst  in  32  raw instruction
in_pc  in  PC_W  instruction PC
out_valid  out  1  head entry valid; equals (count != 0)
out_ready  in  1  consumer takes the head entry
out_pc  out  PC_W  head PC
out_inst  out  32  head raw instruction
out_class  out  4  0 R, 1 I-alu, 2 load, 3 store, 4 branch, 5 lui, 6 auipc, 7 jal, 8 jalr, 9 system, 15 illegal
out_rd, out_rs1, out_rs2  out  5 each  register indices
out_funct3  out  3  inst[14:12]
out_imm  out  XLEN  sign-extended immediate
out_we_reg  out  1  writes rd
out_use_rs1, out_use_rs2  out  1 each  operand usage
out_word  out  1  32-bit-word op (opcode 01110/00110)
out_illegal, out_ecall, out_ebreak, out_mret  out  1 each  exception/system flags
illegal_cnt  out  CNT_W  saturating count of illegal instructions pushed
count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (rstn=0 at a clock edge): count=0, read and write pointers 0, every storage entry zeroed, illegal_cnt=0. Consequently out_valid=0, in_ready=1 and all out_* fields read 0.
- Push = in_valid && in_ready && !flush. Pop = out_valid && out_ready && !flush.
- Decode is combinational on in_inst at push time; the decoded entry is stored, so latency is 1 cycle: pushed at edge N, visible at the outputs after edge N (when the queue was empty).
- in_ready depends only on count, never on out_ready. When full, a pop and a push cannot occur together. When neither full nor empty, simultaneous push and pop leave count unchanged.
- Pointers wrap modulo DEPTH.
- flush=1: count, pointers and head go to 0 at the next edge, and in_inst in that cycle is not accepted. Flush takes priority over push and pop. illegal_cnt is unaffected.
- Illegal when any of the following holds:
  - inst[1:0] != 11;
  - opcode[6:2] is not one of 01100, 00100, 00000, 01000, 11000, 01101, 00101, 11011, 11001, 11100, or (when RV64=1) 01110 or 00110;
  - opcode 11100 with funct3=000 and inst not one of 0x00000073 (ecall), 0x00100073 (ebreak), 0x30200073 (mret).
- Illegal entry: class=15, out_illegal=1, out_inst and out_pc carried through, all other decoded fields 0.
- Immediates are sign-extended from inst[31]:
  - I-type for I-alu, load, jalr and system;
  - S-type for store; B-type for branch; J-type for jal;
  - U-type (inst[31:12]<<12) for lui and auipc;
  - R-type immediate is 0.
- out_we_reg = class in {R, I-alu, load, lui, auipc, jal, jalr}, or system with funct3!=0; always gated by rd!=0.
- out_use_rs1 = class in {R, I-alu, load, store, branch, jalr}, or system with funct3 in {001, 010, 011}.
- out_use_rs2 = class in {R, store, branch}.
- Unused register index fields are driven 0.
- illegal_cnt increments by 1 on every push of an illegal entry and saturates at all-ones.

Test Plan:
- Reset then push addi x1,x0,-1 (0xFFF00093) with out_ready=1 → next cycle: out_valid=1, class=1, rd=1, rs1=0, imm=0xFFFF_FFFF_FFFF_FFFF, we_reg=1, use_rs2=0.
- out_ready=0, push 5 back-to-back instructions, DEPTH=4 → in_ready=0 after the 4th push and the 5th is held; count=4; the pops then drain the 4 entries in order and count returns to 0.
- Push 0x0000003B (addw) with RV64=0 → illegal=1, class=15, illegal_cnt=1. The same instruction with RV64=1 → class=0, word=1, illegal_cnt unchanged.
- Push ecall 0x00000073, ebreak 0x00100073, mret 0x30200073, then 0x00200073 → ecall, ebreak and mret flags set on entries 1-3; the 4th entry has illegal=1.
- Fill 3 entries, assert flush together with in_valid=1 → next cycle count=0, out_valid=0, the flush-cycle instruction is absent, illegal_cnt is retained.
- CNT_W=2, push 5 illegal instructions (e.g. 0x00000000) → illegal_cnt reads 1, 2, 3, 3, 3.
